// File: rtl/moka_rv32i_dmem.sv
// moka_rv32i_dmem: data memory stage for the single-cycle RV32I core.
// Holds the data RAM and a 16-byte MMIO window:
//   - 64-bit cycle counter, read through CNT_LO/CNT_HI with a shadow for the high half
//   - scratch register
//   - sticky error status register
// Loads return in the same cycle. Stores commit on the rising clock edge.
//
// Bus handshake: en qualifies every field of the access for exactly one
// cycle. There is no backpressure, so the core may treat the access as
// accepted whenever en=1. rd_data, misaligned and access_fault describe the
// access presented in that same cycle and read 0 when en=0 or rstn=0.
module moka_rv32i_dmem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  output logic [31:0] rd_data,
  output logic        misaligned,
  output logic        access_fault
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] OFF_CNT_LO  = 2'd0;
  localparam logic [1:0] OFF_CNT_HI  = 2'd1;
  localparam logic [1:0] OFF_SCRATCH = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  // Storage
  logic [31:0] mem [DEPTH_WORDS];
  logic [63:0] counter;
  logic [31:0] hi_shadow;
  logic [31:0] scratch;
  logic [1:0]  status_q;   // bit0 sticky misaligned, bit1 sticky access_fault

  // Decode
  logic [31:0]   ram_off;
  logic [AW-1:0] word_idx;
  logic          ram_hit;
  logic          mmio_hit;
  logic          mmio_sel;
  logic [1:0]    mmio_off;
  logic          is_half;
  logic          is_word;
  logic          f3_illegal;
  logic          mis_raw;
  logic          flt_raw;
  logic          active;
  logic          ld_ok;
  logic          st_ok;

  // Datapath
  logic [31:0] ram_word;
  logic [31:0] ram_shift;
  logic [31:0] ram_ext;
  logic [31:0] mmio_rd;
  logic [3:0]  be_base;
  logic [3:0]  be_sh;
  logic [31:0] wdata_sh;
  logic [1:0]  status_set;
  logic [1:0]  status_clr;

  // Address decode, alignment and legality of the current access
  always_comb begin
    ram_off    = address - RAM_BASE;
    word_idx   = ram_off[AW+1:2];
    ram_hit    = ({1'b0, ram_off} < RAM_BYTES);
    mmio_hit   = (address[31:4] == MMIO_BASE[31:4]);
    // RAM wins if a parameter choice ever makes the two windows overlap
    mmio_sel   = mmio_hit & ~ram_hit;
    mmio_off   = address[3:2];
    is_half    = (funct3 == F3_H) || (funct3 == F3_HU);
    is_word    = (funct3 == F3_W);
    f3_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    mis_raw    = (is_half & address[0]) | (is_word & (address[1:0] != 2'b00));
    flt_raw    = ~(ram_hit | mmio_hit)
               | f3_illegal
               | (mem_we & ((funct3 == F3_BU) || (funct3 == F3_HU)))
               | (mmio_sel & ~is_word);
    active     = en & rstn;
    ld_ok      = active & ~mis_raw & ~flt_raw & ~mem_we;
    st_ok      = active & ~mis_raw & ~flt_raw & mem_we;
  end

  // Load path: lane steering, extension and MMIO read mux
  always_comb begin
    ram_word  = mem[word_idx];
    ram_shift = ram_word >> {address[1:0], 3'b000};
    ram_ext   = ram_shift;
    case (funct3)
      F3_B:    ram_ext = {{24{ram_shift[7]}}, ram_shift[7:0]};
      F3_BU:   ram_ext = {24'h0, ram_shift[7:0]};
      F3_H:    ram_ext = {{16{ram_shift[15]}}, ram_shift[15:0]};
      F3_HU:   ram_ext = {16'h0, ram_shift[15:0]};
      default: ram_ext = ram_shift;
    endcase
    mmio_rd = 32'h0;
    case (mmio_off)
      OFF_CNT_LO:  mmio_rd = counter[31:0];
      OFF_CNT_HI:  mmio_rd = hi_shadow;
      OFF_SCRATCH: mmio_rd = scratch;
      OFF_STATUS:  mmio_rd = {30'h0, status_q};
      default:     mmio_rd = 32'h0;
    endcase
    // Stores and erroring accesses return 0; only good loads carry data
    rd_data = 32'h0;
    if (ld_ok) rd_data = ram_hit ? ram_ext : mmio_rd;
    misaligned   = active & mis_raw;
    access_fault = active & flt_raw;
  end

  // Store path: byte-enable mask and data steered onto the addressed lanes
  always_comb begin
    case (funct3)
      F3_B:    be_base = 4'b0001;
      F3_H:    be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    be_sh    = 4'(be_base << address[1:0]);
    wdata_sh = wr_data << {address[1:0], 3'b000};
  end

  // RAM write port; the read above is asynchronous, so a same-cycle load sees old data
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (st_ok && ram_hit && be_sh[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
  end

  // Sticky error bits set on erroring accesses; W1C clears lose to a same-edge set
  always_comb begin
    status_set = {en & flt_raw, en & mis_raw};
    status_clr = (st_ok && mmio_sel && mmio_off == OFF_STATUS) ? wr_data[1:0] : 2'b00;
  end

  // MMIO state: free-running counter, tear-free high shadow, scratch, status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counter   <= 64'h0;
      hi_shadow <= 32'h0;
      scratch   <= 32'h0;
      status_q  <= 2'b00;
    end else begin
      counter  <= counter + 64'd1;
      status_q <= (status_q & ~status_clr) | status_set;
      if (ld_ok && mmio_sel && mmio_off == OFF_CNT_LO) hi_shadow <= counter[63:32];
      if (st_ok && mmio_sel && mmio_off == OFF_SCRATCH) scratch <= wr_data;
    end
  end

endmodule

// File: tb/tb_moka_rv32i_dmem.sv
// tb_moka_rv32i_dmem: directed scoreboard bench for the data memory stage.
// The driver pushes the hand-computed response of each access into exp_q.
// The monitor pops and compares every cycle in which en is high.
module tb_moka_rv32i_dmem;

  localparam logic [31:0] CNT_LO  = 32'hFFFF_0000;
  localparam logic [31:0] CNT_HI  = 32'hFFFF_0004;
  localparam logic [31:0] SCRATCH = 32'hFFFF_0008;
  localparam logic [31:0] STATUS  = 32'hFFFF_000C;
  localparam logic [2:0]  B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic        mem_we = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] rd_data;
  logic        misaligned;
  logic        access_fault;

  always #5 clk = ~clk;

  moka_rv32i_dmem dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .address      (address),
    .wr_data      (wr_data),
    .mem_we       (mem_we),
    .funct3       (funct3),
    .rd_data      (rd_data),
    .misaligned   (misaligned),
    .access_fault (access_fault)
  );

  // Scoreboard state: {rd_data, misaligned, access_fault}
  logic [33:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er,
                       input logic em, input logic ef);
    en      = 1'b1;
    mem_we  = we;
    funct3  = f3;
    address = a;
    wr_data = wd;
    exp_q.push_back({er, em, ef});
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] er,
                    input logic em = 1'b0, input logic ef = 1'b0);
    @(negedge clk);
    drive(1'b0, f3, a, 32'h0, er, em, ef);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic em = 1'b0, input logic ef = 1'b0);
    @(negedge clk);
    drive(1'b1, f3, a, wd, 32'h0, em, ef);
  endtask

  task automatic idle();
    @(negedge clk);
    en     = 1'b0;
    mem_we = 1'b0;
  endtask

  // Monitor: compares outputs 2 time units after every falling edge
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_access @%h: no expected entry", address);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rd_data @%h", address), 64'(rd_data), 64'(e[33:2]));
          check($sformatf("misaligned @%h", address), 64'(misaligned), 64'(e[1]));
          check($sformatf("access_fault @%h", address), 64'(access_fault), 64'(e[0]));
        end
      end else begin
        check("idle_outputs", {30'h0, rd_data, misaligned, access_fault}, 64'h0);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: stimulus did not complete, got timeout, required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    // Reset state
    #2 rstn = 1'b0;
    #1;
    check("reset_counter", dut.counter, 64'h0);
    check("reset_scratch", 64'(dut.scratch), 64'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    ld(W, SCRATCH, 32'h0);
    ld(W, STATUS,  32'h0);
    ld(W, CNT_HI,  32'h0);

    // Test 1: lane steering and extension
    st(W,  32'h10, 32'hDEAD_BEEF);
    ld(B,  32'h13, 32'hFFFF_FFDE);
    ld(BU, 32'h13, 32'h0000_00DE);
    ld(B,  32'h10, 32'hFFFF_FFEF);
    ld(H,  32'h10, 32'hFFFF_BEEF);
    ld(HU, 32'h12, 32'h0000_DEAD);
    ld(W,  32'h10, 32'hDEAD_BEEF);

    // Test 2: partial stores preserve other lanes
    st(W, 32'h20, 32'h1122_3344);
    st(B, 32'h21, 32'h0000_00AA);
    st(H, 32'h22, 32'h0000_5566);
    ld(W, 32'h20, 32'h5566_AA44);

    // Test 3: misaligned accesses
    ld(W, 32'h22, 32'h0, 1'b1, 1'b0);
    st(H, 32'h23, 32'h0000_FFFF, 1'b1, 1'b0);
    ld(W, 32'h20, 32'h5566_AA44);
    ld(W, STATUS, 32'h1);
    st(W, STATUS, 32'h1);
    ld(W, STATUS, 32'h0);

    // Test 4: unmapped and illegal accesses, RAM boundary
    st(W,  SCRATCH, 32'h1234_5678);
    ld(W,  32'h8000_0000, 32'h0, 1'b0, 1'b1);
    st(B,  SCRATCH, 32'h0000_00FF, 1'b0, 1'b1);
    ld(W,  32'h0000_1000, 32'h0, 1'b0, 1'b1);
    st(W,  32'h0000_0FFC, 32'hA5A5_5A5A);
    ld(W,  32'h0000_0FFC, 32'hA5A5_5A5A);
    st(HU, 32'h30, 32'h1, 1'b0, 1'b1);
    ld(3'b011, 32'h0, 32'h0, 1'b0, 1'b1);
    ld(B,  CNT_LO, 32'h0, 1'b0, 1'b1);
    ld(W,  SCRATCH, 32'h1234_5678);
    ld(W,  STATUS, 32'h2);
    st(B,  STATUS, 32'h2, 1'b0, 1'b1);   // faulting clear attempt: set wins, bit1 stays
    ld(W,  STATUS, 32'h2);
    st(W,  STATUS, 32'h2);
    ld(W,  STATUS, 32'h0);
    ld(W,  32'h8000_0002, 32'h0, 1'b1, 1'b1);
    ld(W,  STATUS, 32'h3);
    st(W,  STATUS, 32'h3);
    ld(W,  STATUS, 32'h0);

    // Test 5: tear-free counter read across a 32-bit rollover
    @(negedge clk);
    force dut.counter = 64'h0000_0001_FFFF_FFFF;
    drive(1'b0, W, CNT_LO, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    release dut.counter;
    drive(1'b0, W, CNT_HI, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
    idle();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b0, W, CNT_LO, 32'h0, 32'h0, 1'b0, 1'b0);
    ld(W, CNT_HI, 32'h0);
    ld(W, CNT_LO, 32'h2);

    // Test 6: asynchronous reset with a store in flight
    st(W, SCRATCH, 32'hCAFE_F00D);
    ld(W, 32'h22, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, W, SCRATCH, 32'h0000_0055, 32'h0, 1'b0, 1'b0);
    #3 rstn = 1'b0;
    #1;
    check("async_outputs", {30'h0, rd_data, misaligned, access_fault}, 64'h0);
    check("async_scratch", 64'(dut.scratch), 64'h0);
    check("async_status", 64'(dut.status_q), 64'h0);
    check("async_counter", dut.counter, 64'h0);
    @(negedge clk);
    en     = 1'b0;
    mem_we = 1'b0;
    rstn   = 1'b1;
    ld(W, SCRATCH, 32'h0);
    ld(W, STATUS,  32'h0);
    ld(W, 32'h10,  32'hDEAD_BEEF);

    // Drain and report
    idle();
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
